// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S blocks.
//   play_state_t   : playback sequencer states
//   srate()        : clock cycles per sample period (CLK / SAMPLE_RATE)
//   DATA_WIDTH_DEF : default sample width
package i2s_pkg;

  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    LOAD      = 2'd2,
    WAIT_TICK = 2'd3
  } play_state_t;

  function automatic int srate(input int clk_hz, input int sample_rate);
    return clk_hz / sample_rate;
  endfunction

endpackage

// File: rtl/i2s_rate_gen.sv
// Sample-period counter.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear of the count to 0 (wins over en)
//   en         : count enable; count runs 0..SRATE-1 and wraps
//   tick       : high while count == SRATE-2 and enabled, so a registered
//                strobe launched from it is visible while count == SRATE-1
module i2s_rate_gen #(
  parameter int SRATE = 1280,
  parameter int CW    = $clog2(SRATE)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == CW'(SRATE - 1)) count <= '0;
      else                         count <= count + CW'(1);
    end
  end

  assign tick = en && !clr && (count == CW'(SRATE - 2));

endmodule

// File: rtl/i2s_playback_ctrl.sv
// Playback sequencer: reads a window of a sync-read sample RAM and presents
// one word per sample period to the I2S serializer as a 1-cycle strobe.
// Optional feature macro: I2S_PLAY_REPEAT_EN adds cfg_repeat[7:0]; a
// non-loop run then plays the window cfg_repeat+1 times before done.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   start, stop         : 1-cycle start / abort pulses
//   cfg_base, cfg_last  : inclusive address window, captured on accepted start
//   cfg_loop            : wrap forever, captured on accepted start
//   cfg_repeat          : extra window passes (only with I2S_PLAY_REPEAT_EN)
//   ram_rdaddr, ram_rden: RAM read port; ram_rddata valid one cycle after rden
//   tx_data, tx_valid   : sample and its 1-cycle strobe, data held between strobes
//   busy, done          : run active; 1-cycle pulse after a non-loop run ends
//   dbg_state           : current sequencer state
// Handshake: tx_valid is a pure strobe with no back-pressure; the serializer
// must take tx_data in the cycle tx_valid is high. ram_rden is a single-cycle
// request and ram_rddata is consumed exactly one cycle later.
module i2s_playback_ctrl
  import i2s_pkg::*;
#(
  parameter int CLK         = 44_000_000,
  parameter int SAMPLE_RATE = 34375,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_last,
  input  logic                  cfg_loop,
`ifdef I2S_PLAY_REPEAT_EN
  input  logic [7:0]            cfg_repeat,
`endif
  output logic [ADDR_WIDTH-1:0] ram_rdaddr,
  output logic                  ram_rden,
  input  logic [DATA_WIDTH-1:0] ram_rddata,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  busy,
  output logic                  done,
  output play_state_t           dbg_state
);

  localparam int SRATE = srate(CLK, SAMPLE_RATE);

  play_state_t           state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] last_q;
  logic                  loop_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  finish_q;  // last strobe of a run went out this cycle
`ifdef I2S_PLAY_REPEAT_EN
  logic [7:0]            rep_q;
`endif

  logic accept;
  logic tick;

  assign accept    = (state == IDLE) && start && !stop;
  assign dbg_state = state;

  // The period counter restarts with each accepted start so the first
  // strobe position is fixed relative to busy rising.
  i2s_rate_gen #(.SRATE(SRATE)) u_rate (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (busy),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      base_q     <= '0;
      last_q     <= '0;
      loop_q     <= 1'b0;
      hold_q     <= '0;
      finish_q   <= 1'b0;
`ifdef I2S_PLAY_REPEAT_EN
      rep_q      <= '0;
`endif
      ram_rdaddr <= '0;
      ram_rden   <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      ram_rden <= 1'b0;
      tx_valid <= 1'b0;
      finish_q <= 1'b0;
      done     <= finish_q;

      // Abort takes priority over a due strobe, which is thereby dropped.
      if (state != IDLE && stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              base_q     <= cfg_base;
              last_q     <= cfg_last;
              loop_q     <= cfg_loop;
`ifdef I2S_PLAY_REPEAT_EN
              rep_q      <= cfg_repeat;
`endif
              ram_rdaddr <= cfg_base;
              ram_rden   <= 1'b1;
              busy       <= 1'b1;
              state      <= FETCH;
            end
          end
          FETCH: state <= LOAD;
          LOAD: begin
            hold_q <= ram_rddata;
            state  <= WAIT_TICK;
          end
          WAIT_TICK: begin
            if (tick) begin
              tx_data  <= hold_q;
              tx_valid <= 1'b1;
              if (ram_rdaddr == last_q) begin
                if (loop_q) begin
                  ram_rdaddr <= base_q;
                  ram_rden   <= 1'b1;
                  state      <= FETCH;
                end
`ifdef I2S_PLAY_REPEAT_EN
                else if (rep_q != 8'd0) begin
                  rep_q      <= rep_q - 8'd1;
                  ram_rdaddr <= base_q;
                  ram_rden   <= 1'b1;
                  state      <= FETCH;
                end
`endif
                else begin
                  busy     <= 1'b0;
                  finish_q <= 1'b1;
                  state    <= IDLE;
                end
              end else begin
                // Wraps through 2^ADDR_WIDTH-1 to 0 when last < base.
                ram_rdaddr <= ram_rdaddr + ADDR_WIDTH'(1);
                ram_rden   <= 1'b1;
                state      <= FETCH;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_playback_ctrl.sv
module tb_i2s_playback_ctrl;
  import i2s_pkg::*;

  localparam int SRATE = 16;  // 1600 / 100

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start, stop, cfg_loop;
  logic [7:0]  cfg_base, cfg_last, cfg_repeat;
  logic [7:0]  ram_rdaddr;
  logic        ram_rden;
  logic [15:0] ram_rddata;
  logic [15:0] tx_data;
  logic        tx_valid, busy, done;
  play_state_t dbg_state;

  i2s_playback_ctrl #(
    .CLK(1600), .SAMPLE_RATE(100), .DATA_WIDTH(16), .ADDR_WIDTH(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .cfg_base   (cfg_base),
    .cfg_last   (cfg_last),
    .cfg_loop   (cfg_loop),
`ifdef I2S_PLAY_REPEAT_EN
    .cfg_repeat (cfg_repeat),
`endif
    .ram_rdaddr (ram_rdaddr),
    .ram_rden   (ram_rden),
    .ram_rddata (ram_rddata),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // sync-read RAM model
  logic [15:0] ram [256];
  always @(posedge clk) if (ram_rden) ram_rddata <= ram[ram_rdaddr];

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  addr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] base;
    logic [7:0] last;
    logic       loop;
    int         nstr;     // strobes to observe
    int         stop_at;  // >0: stop this many cycles after the last observed strobe
    logic       repulse;  // re-pulse start mid-run with a different config
    logic [7:0] reps;
  } case_t;

  case_t cases[6];

  task automatic run_case(input case_t c);
    int cyc, t0, ls, seen, stop_cyc, budget;
    bit done_seen, fin;
    logic [7:0] a;
    exp_q.delete();
    addr_q.delete();
    a = c.base;
    for (int i = 0; i < c.nstr; i++) begin
      addr_q.push_back(a);
      exp_q.push_back(ram[a]);
      if (a == c.last) a = c.base;
      else a = a + 8'd1;
    end
    // stopped runs have already fetched the next word when stop arrives
    if (c.stop_at > 0) addr_q.push_back(a);

    @(negedge clk);
    cfg_base = c.base; cfg_last = c.last; cfg_loop = c.loop; cfg_repeat = c.reps;
    start = 1'b1;
    cyc = 0; t0 = 0; ls = 0; seen = 0; stop_cyc = 0; done_seen = 0; fin = 0;
    budget = SRATE * (c.nstr + 4) + 20;
    for (int k = 0; k < budget && !fin; k++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      stop  = 1'b0;
      if (k == 0) begin
        chk("busy_rise", busy, 1);
        t0 = cyc;
      end
      if (ram_rden) begin
        if (addr_q.size() == 0) chk("extra_read", 1, 0);
        else chk("rd_addr", ram_rdaddr, addr_q.pop_front());
      end
      if (tx_valid) begin
        if (exp_q.size() == 0) chk("extra_strobe", 1, 0);
        else begin
          chk("tx_data", tx_data, exp_q.pop_front());
          chk("strobe_gap", cyc - ((seen == 0) ? t0 : ls), (seen == 0) ? SRATE - 1 : SRATE);
          seen++;
          ls = cyc;
        end
      end
      if (done) begin
        done_seen = 1;
        chk("done_after_last", cyc - ls, 1);
        chk("done_busy", busy, 0);
      end
      if (c.repulse && cyc == t0 + 5) begin
        cfg_base = 8'd2; cfg_last = 8'd9; cfg_loop = 1'b1;
        start = 1'b1;
      end
      if (c.stop_at > 0 && stop_cyc == 0 && seen == c.nstr && cyc == ls + c.stop_at) begin
        chk("busy_before_stop", busy, 1);
        stop = 1'b1;
        stop_cyc = cyc;
      end
      if (stop_cyc > 0 && cyc == stop_cyc + 1) chk("busy_after_stop", busy, 0);
      if (c.stop_at == 0 && done_seen && cyc == ls + 3) fin = 1;
      if (stop_cyc > 0 && cyc == stop_cyc + 2 * SRATE) fin = 1;
    end
    chk("run_finished", fin, 1);
    chk("strobe_count", seen, c.nstr);
    chk("done_seen", done_seen, (c.stop_at == 0) ? 1 : 0);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("addr_q_empty", addr_q.size(), 0);
    chk("busy_end", busy, 0);
  endtask

  int viol;

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_loop = 1'b0;
    cfg_base = '0; cfg_last = '0; cfg_repeat = '0;
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom_range(0, 16'hFFFF));
    ram[0] = 16'hC2A3; ram[1] = 16'h43F5; ram[2] = 16'h7788; ram[3] = 16'hFFFF;

    cases[0] = '{8'h00, 8'h03, 1'b0, 4, 0,  1'b0, 8'd0};
    cases[1] = '{8'h00, 8'h03, 1'b1, 5, 3,  1'b0, 8'd0};
    cases[2] = '{8'hFE, 8'h01, 1'b0, 4, 0,  1'b0, 8'd0};
    cases[3] = '{8'h00, 8'h03, 1'b0, 2, 10, 1'b0, 8'd0};
    cases[4] = '{8'h00, 8'h03, 1'b0, 4, 0,  1'b1, 8'd0};
    cases[5] = '{8'h05, 8'h05, 1'b0, 1, 0,  1'b0, 8'd0};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_rden", ram_rden, 0);
    chk("rst_rdaddr", ram_rdaddr, 0);
    chk("rst_tx_data", tx_data, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_case(cases[i]);

`ifdef I2S_PLAY_REPEAT_EN
    begin
      case_t rc;
      rc = '{8'h01, 8'h01, 1'b0, 3, 0, 1'b0, 8'd2};
      run_case(rc);
    end
`endif

    // start && stop together in IDLE: no run
    @(negedge clk);
    cfg_base = 8'h00; cfg_last = 8'h03; cfg_loop = 1'b0;
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", busy, 0);
    viol = 0;
    for (int k = 0; k < SRATE; k++) begin
      @(negedge clk);
      if (busy || ram_rden || tx_valid || done) viol++;
    end
    chk("start_stop_idle", viol, 0);

    // asynchronous reset mid-WAIT_TICK, after one strobe has loaded tx_data
    @(negedge clk);
    cfg_base = 8'h00; cfg_last = 8'h03; cfg_loop = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SRATE + 4) @(negedge clk);
    chk("pre_reset_state", dbg_state, WAIT_TICK);
    chk("pre_reset_tx_data", tx_data, 16'hC2A3);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_tx_data", tx_data, 0);
    chk("async_rdaddr", ram_rdaddr, 0);
    chk("async_state", dbg_state, IDLE);
    @(negedge clk);
    reset = 1'b0;
    viol = 0;
    for (int k = 0; k < 2 * SRATE; k++) begin
      @(negedge clk);
      if (busy || ram_rden || tx_valid || done) viol++;
    end
    chk("post_reset_quiet", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
